// File: rtl/ultrasonic_pkg.sv
// Shared types, 27 MHz default timing constants and a width helper for the
// ultrasonic ranging controller.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int DEF_CLK_HZ      = 27_000_000;
  localparam int DEF_TRIG_CYC    = 270;        // 10 us trigger pulse
  localparam int DEF_PERIOD_CYC  = 6_750_000;  // 250 ms free-run interval
  localparam int DEF_TIMEOUT_CYC = 810_000;    // 30 ms echo wait / echo width limit
  localparam int DEF_CYC_PER_CM  = 1562;       // echo-high cycles per centimetre

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous echo pin, followed by a
// registered rise/fall detector on the synchronised level.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_echo,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;
  logic r_fall;

  // Synchronise the pin and register one-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_echo;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranging controller: trigger generation, echo timing with timeout,
// prescaled centimetre conversion, optional averaging and a valid/ready
// result port with overrun indication.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TRIG_CYC    = CLK_HZ / 100_000,
  parameter int PERIOD_CYC  = CLK_HZ / 4,
  parameter int TIMEOUT_CYC = (CLK_HZ / 1000) * 30,
  parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
  parameter int DIST_W      = 9,
  parameter int AVG_LOG2    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_timeout,
  output logic              dist_valid,
  input  logic              dist_ready,
  output logic              overrun
);

  localparam int PW = clog2(PERIOD_CYC);
  localparam int TW = clog2((TIMEOUT_CYC > TRIG_CYC) ? TIMEOUT_CYC : TRIG_CYC);
  localparam int CW = clog2(CYC_PER_CM);
  localparam int AW = DIST_W + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  localparam logic [PW-1:0]     PER_LAST  = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0]     TRIG_LAST = TW'(TRIG_CYC - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]     PS_LAST   = CW'(CYC_PER_CM - 1);
  localparam logic [NW-1:0]     N_LAST    = NW'((1 << AVG_LOG2) - 1);
  localparam logic [DIST_W-1:0] MAX_CM    = {DIST_W{1'b1}};

  state_t            r_state;
  logic              r_trig;
  logic              r_busy;
  logic [PW-1:0]     r_period;
  logic [TW-1:0]     r_tmr;
  logic [CW-1:0]     r_ps;
  logic [DIST_W-1:0] r_cm;
  logic [AW-1:0]     r_acc;
  logic [NW-1:0]     r_nsamp;
  logic [DIST_W-1:0] r_dist_cm;
  logic              r_dist_to;
  logic              r_dist_valid;
  logic              r_overrun;

  logic              w_rise;
  logic              w_fall;
  logic              w_period_exp;
  logic              w_ps_wrap;
  logic [DIST_W-1:0] w_cm_next;
  logic              w_good;
  logic              w_timeout;
  logic [AW-1:0]     w_sum;
  logic              w_pub;
  logic [DIST_W-1:0] w_pub_cm;

  echo_sync u_echo_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_echo (echo),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Derive this cycle's cm value, sample/timeout events and publish data.
  always_comb begin
    w_period_exp = (r_period == PER_LAST);
    w_ps_wrap    = (r_ps == PS_LAST);
    if (w_ps_wrap && (r_cm != MAX_CM)) begin
      w_cm_next = r_cm + 1'b1;
    end else begin
      w_cm_next = r_cm;
    end
    w_good    = (r_state == ST_MEASURE) && w_fall;
    w_timeout = (r_tmr == TO_LAST) &&
                (((r_state == ST_WAIT_RISE) && !w_rise) ||
                 ((r_state == ST_MEASURE) && !w_fall));
    w_sum     = r_acc + AW'(w_cm_next);
    w_pub     = w_timeout || (w_good && (r_nsamp == N_LAST));
    if (w_timeout) begin
      w_pub_cm = MAX_CM;
    end else begin
      w_pub_cm = DIST_W'(w_sum >> AVG_LOG2);
    end
  end

  // Measurement sequencer with registered trigger, busy and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_trig   <= 1'b0;
      r_busy   <= 1'b0;
      r_period <= PER_LAST;
      r_tmr    <= {TW{1'b0}};
      r_ps     <= {CW{1'b0}};
      r_cm     <= {DIST_W{1'b0}};
    end else begin
      if (!w_period_exp) begin
        r_period <= r_period + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start || (en && w_period_exp)) begin
            r_state  <= ST_TRIG;
            r_trig   <= 1'b1;
            r_busy   <= 1'b1;
            r_period <= {PW{1'b0}};
            r_tmr    <= {TW{1'b0}};
          end
        end
        ST_TRIG: begin
          if (r_tmr == TRIG_LAST) begin
            r_state <= ST_WAIT_RISE;
            r_trig  <= 1'b0;
            r_tmr   <= {TW{1'b0}};
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_tmr   <= {TW{1'b0}};
            r_ps    <= {CW{1'b0}};
            r_cm    <= {DIST_W{1'b0}};
          end else if (w_timeout) begin
            r_state <= ST_HOLDOFF;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (w_fall || w_timeout) begin
            r_state <= ST_HOLDOFF;
          end else begin
            r_tmr <= r_tmr + 1'b1;
            r_ps  <= w_ps_wrap ? {CW{1'b0}} : (r_ps + 1'b1);
            r_cm  <= w_cm_next;
          end
        end
        ST_HOLDOFF: begin
          if (!en) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_period_exp) begin
            r_state  <= ST_TRIG;
            r_trig   <= 1'b1;
            r_period <= {PW{1'b0}};
            r_tmr    <= {TW{1'b0}};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_trig  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Averaging accumulator: sum good samples, restart on publish or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= {AW{1'b0}};
      r_nsamp <= {NW{1'b0}};
    end else if (w_pub) begin
      r_acc   <= {AW{1'b0}};
      r_nsamp <= {NW{1'b0}};
    end else if (w_good) begin
      r_acc   <= w_sum;
      r_nsamp <= r_nsamp + 1'b1;
    end
  end

  // Result register with valid/ready handshake; a new result always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dist_cm    <= {DIST_W{1'b0}};
      r_dist_to    <= 1'b0;
      r_dist_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_pub) begin
      r_dist_cm    <= w_pub_cm;
      r_dist_to    <= w_timeout;
      r_dist_valid <= 1'b1;
      r_overrun    <= r_dist_valid & ~dist_ready;
    end else begin
      r_overrun <= 1'b0;
      if (r_dist_valid && dist_ready) begin
        r_dist_valid <= 1'b0;
      end
    end
  end

  assign trig         = r_trig;
  assign busy         = r_busy;
  assign dist_cm      = r_dist_cm;
  assign dist_timeout = r_dist_to;
  assign dist_valid   = r_dist_valid;
  assign overrun      = r_overrun;

endmodule
